// File: rtl/rom_reader_pkg.sv
// rom_reader_pkg: chip geometry, operation codes and FSM states shared by the ROM reader.
package rom_reader_pkg;
    localparam int IP3604_DATA_WIDTH    = 8;
    localparam int IP3604_ADDRESS_WIDTH = 9;
    localparam int IP3604_DEPTH         = 512;
    localparam int IP3601_DATA_WIDTH    = 4;
    localparam int IP3601_ADDRESS_WIDTH = 8;
    localparam int IP3601_DEPTH         = 256;
    localparam logic [3:0] OP_READ_CODE = 4'b1100;
    localparam logic [3:0] OP_IDLE_CODE = 4'b1111;
    typedef enum logic [1:0] {IDLE, SETUP, SAMPLE, HOLD} state_e;
endpackage

// File: rtl/rom_address_counter.sv
// rom_address_counter: chip address register with clear, up and down steps wrapping at DEPTH-1 <-> 0.
module rom_address_counter #(
    parameter int ADDRESS_WIDTH = 9,
    parameter int DEPTH         = 512
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clr_i,
    input  logic                     inc_i,
    input  logic                     dec_i,
    output logic [ADDRESS_WIDTH-1:0] addr_o,
    output logic                     last_o
);
    localparam logic [ADDRESS_WIDTH-1:0] LAST = ADDRESS_WIDTH'(DEPTH - 1);
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    always_comb begin
        last_o = addr_q == LAST;
        addr_d = clr_i ? '0
               : inc_i ? (last_o ? '0 : addr_q + 1'b1)
               : dec_i ? (addr_q == '0 ? LAST : addr_q - 1'b1)
               : addr_q;
        addr_o = addr_q;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) addr_q <= '0;
        else          addr_q <= addr_d;
    end
endmodule

// File: rtl/rom_scan_reader.sv
// rom_scan_reader: reads a 556PT-class ROM by auto scan or manual stepping and streams
// each word with its address over valid/ready.
module rom_scan_reader
    import rom_reader_pkg::*;
#(
    parameter int         DATA_WIDTH    = IP3604_DATA_WIDTH,
    parameter int         ADDRESS_WIDTH = IP3604_ADDRESS_WIDTH,
    parameter int         DEPTH         = IP3604_DEPTH,
    parameter int         ACCESS_CYCLES = 4,
    parameter logic [3:0] OP_READ       = OP_READ_CODE,
    parameter logic [3:0] OP_IDLE       = OP_IDLE_CODE
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     mode,
    input  logic                     start,
    input  logic                     step_inc,
    input  logic                     step_dec,
    input  logic [DATA_WIDTH-1:0]    data_line_in,
    output logic [3:0]               operation,
    output logic [ADDRESS_WIDTH-1:0] address_line,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic [ADDRESS_WIDTH-1:0] data_addr,
    output logic                     data_valid,
    input  logic                     data_ready,
    output logic                     busy,
    output logic                     done
);
    localparam int WW = $clog2(ACCESS_CYCLES + 1);
    localparam logic [WW-1:0] WAIT_LOAD = WW'(ACCESS_CYCLES - 1);

    state_e                   state_q, state_d;
    logic [WW-1:0]            wait_q, wait_d;
    logic                     mode_q, mode_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [ADDRESS_WIDTH-1:0] daddr_q, daddr_d;
    logic                     valid_q, valid_d, done_q, done_d;
    logic idle, go_start, go_inc, go_dec, accept, capture, take, last;
    logic cnt_clr, cnt_inc, cnt_dec;

    always_comb begin
        idle     = state_q == IDLE;
        go_start = idle && start;
        go_inc   = idle && !start && !mode && step_inc && !step_dec;
        go_dec   = idle && !start && !mode && step_dec && !step_inc;
        accept   = go_start || go_inc || go_dec;
        capture  = state_q == SETUP && wait_q == '0;
        take     = state_q == HOLD && valid_q && data_ready;
        cnt_clr  = go_start && mode;
        cnt_inc  = go_inc || (take && mode_q && !last);
        cnt_dec  = go_dec;
    end

    rom_address_counter #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DEPTH        (DEPTH)
    ) u_addr (
        .clk    (clk),
        .reset_n(reset_n),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .dec_i  (cnt_dec),
        .addr_o (address_line),
        .last_o (last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // SAMPLE is the capture edge closing SETUP; no cycle is spent in it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? SETUP : IDLE;
            SETUP:   state_d = capture ? HOLD : SETUP;
            HOLD:    state_d = !take ? HOLD : (mode_q && !last) ? SETUP : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        operation  = idle ? OP_IDLE : OP_READ;
        busy       = !idle;
        data_out   = data_q;
        data_addr  = daddr_q;
        data_valid = valid_q;
        done       = done_q;
    end

    always_comb begin
        wait_d  = (state_q == SETUP && wait_q != '0) ? wait_q - 1'b1 : WAIT_LOAD;
        mode_d  = accept ? mode : mode_q;
        data_d  = capture ? data_line_in : data_q;
        daddr_d = capture ? address_line : daddr_q;
        valid_d = capture ? 1'b1 : take ? 1'b0 : valid_q;
        done_d  = take && mode_q && last;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_q  <= WAIT_LOAD;
            mode_q  <= 1'b0;
            data_q  <= '0;
            daddr_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            wait_q  <= wait_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
            daddr_q <= daddr_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_rom_scan_reader.sv
// tb_rom_scan_reader: directed scoreboard bench for the IP3604 and IP3601 configurations.
module tb_rom_scan_reader;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n;

    logic       mode_a, start_a, inc_a, dec_a, ready_a, valid_a, busy_a, done_a;
    logic [7:0] din_a, dout_a;
    logic [8:0] addr_a, daddr_a;
    logic [3:0] op_a;
    logic       mode_b, start_b, ready_b, valid_b, busy_b, done_b;
    logic [3:0] din_b, dout_b, op_b;
    logic [7:0] addr_b, daddr_b;

    assign din_a = addr_a[7:0] ^ 8'hA5;
    assign din_b = addr_b[3:0] ^ 4'h5;

    rom_scan_reader dut_a (
        .clk(clk), .reset_n(reset_n), .mode(mode_a), .start(start_a),
        .step_inc(inc_a), .step_dec(dec_a), .data_line_in(din_a),
        .operation(op_a), .address_line(addr_a), .data_out(dout_a),
        .data_addr(daddr_a), .data_valid(valid_a), .data_ready(ready_a),
        .busy(busy_a), .done(done_a)
    );

    rom_scan_reader #(
        .DATA_WIDTH(4), .ADDRESS_WIDTH(8), .DEPTH(256), .ACCESS_CYCLES(1)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .mode(mode_b), .start(start_b),
        .step_inc(1'b0), .step_dec(1'b0), .data_line_in(din_b),
        .operation(op_b), .address_line(addr_b), .data_out(dout_b),
        .data_addr(daddr_b), .data_valid(valid_b), .data_ready(ready_b),
        .busy(busy_b), .done(done_b)
    );

    int tests = 0;
    int fails = 0;
    typedef struct packed {logic [31:0] a; logic [31:0] d;} exp_t;
    exp_t q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rom(input bit b, input logic [31:0] a);
        return b ? {28'd0, a[3:0] ^ 4'h5} : {24'd0, a[7:0] ^ 8'hA5};
    endfunction

    task automatic push(input bit b, input int a);
        q.push_back('{a: a, d: rom(b, a)});
    endtask

    task automatic collect(input bit b, input int n, input bit auto_m, input int stall_at,
                           input int stall_len, input bit poke, input int lat);
        int cyc = 0, beats = 0, dones = 0, first = -1, stall = 0, op_err = 0, take_cyc = -10;
        bit fin = 0, stalling;
        logic v, bz, dn;
        logic [31:0] ad, dt, al;
        logic [3:0] op;
        exp_t e;
        while (!fin && cyc < n * 8 + 100) begin
            @(negedge clk);
            cyc++;
            start_a = 0; start_b = 0; inc_a = 0; dec_a = 0;
            if (poke && cyc == 20) begin
                start_a = 1; inc_a = 1; mode_a = ~mode_a;
            end
            v  = b ? valid_b : valid_a;
            bz = b ? busy_b : busy_a;
            dn = b ? done_b : done_a;
            op = b ? op_b : op_a;
            ad = b ? 32'(daddr_b) : 32'(daddr_a);
            dt = b ? 32'(dout_b) : 32'(dout_a);
            al = b ? 32'(addr_b) : 32'(addr_a);
            if (op !== (bz ? 4'b1100 : 4'b1111)) op_err++;
            if (v && first < 0) first = cyc;
            if (dn) begin
                dones++;
                check("done_after_last", cyc, take_cyc + 1);
                check("done_busy_low", 32'(bz), 0);
                check("done_beat_count", beats, n);
            end
            stalling = v && beats == stall_at && stall < stall_len;
            if (stalling && q.size() > 0) begin
                stall++;
                check("stall_data_addr", ad, q[0].a);
                check("stall_data_out", dt, q[0].d);
                check("stall_address_line", al, q[0].a);
            end
            if (b) ready_b = !stalling; else ready_a = !stalling;
            if (v && !stalling) begin
                check("sb_nonempty", 32'(q.size() != 0), 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("beat_addr", ad, e.a);
                    check("beat_data", dt, e.d);
                end
                beats++;
                take_cyc = cyc;
            end
            fin = auto_m ? dones > 0 : beats == n;
        end
        check("no_timeout", 32'(fin), 1);
        @(negedge clk);
        check("end_busy", 32'(b ? busy_b : busy_a), 0);
        check("end_valid", 32'(b ? valid_b : valid_a), 0);
        check("beats", beats, n);
        check("done_pulses", dones, auto_m ? 1 : 0);
        check("first_valid_latency", first, lat);
        check("op_vs_busy_errors", op_err, 0);
        check("scoreboard_empty", q.size(), 0);
        if (stall_at >= 0) check("stall_cycles", stall, stall_len);
    endtask

    task automatic manual_read(input bit inc, input bit dec, input int a);
        @(negedge clk);
        mode_a = 0; inc_a = inc; dec_a = dec; start_a = !inc && !dec;
        push(0, a);
        collect(0, 1, 0, -1, 0, 0, 5);
        check("manual_address_line", 32'(addr_a), a);
    endtask

    task automatic expect_ignored(input string tag);
        int err = 0;
        @(negedge clk);
        start_a = 0; inc_a = 0; dec_a = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy_a || valid_a) err++;
        end
        check(tag, err, 0);
        check({tag, "_addr"}, 32'(addr_a), 0);
    endtask

    initial begin
        reset_n = 0;
        mode_a = 0; start_a = 0; inc_a = 0; dec_a = 0; ready_a = 0;
        mode_b = 0; start_b = 0; ready_b = 0;
        #12;
        check("rst_op", 32'(op_a), 32'hF);
        check("rst_addr", 32'(addr_a), 0);
        check("rst_dout", 32'(dout_a), 0);
        check("rst_daddr", 32'(daddr_a), 0);
        check("rst_flags", {29'd0, valid_a, busy_a, done_a}, 0);
        check("rst_op_b", 32'(op_b), 32'hF);
        @(negedge clk);
        reset_n = 1;

        @(negedge clk);
        mode_a = 1; start_a = 1; ready_a = 1;
        for (int i = 0; i < 512; i++) push(0, i);
        collect(0, 512, 1, -1, 0, 0, 5);
        check("scan1_final_addr", 32'(addr_a), 511);

        @(negedge clk);
        mode_a = 1; start_a = 1;
        for (int i = 0; i < 3000 && addr_a != 9'd100; i++) begin
            @(negedge clk);
            start_a = 0;
        end
        check("reached_100", 32'(addr_a), 100);
        #2 reset_n = 0;
        #1;
        check("midrst_op", 32'(op_a), 32'hF);
        check("midrst_addr", 32'(addr_a), 0);
        check("midrst_flags", {29'd0, valid_a, busy_a, done_a}, 0);
        check("midrst_dout", 32'(dout_a), 0);
        @(negedge clk);
        reset_n = 1;

        @(negedge clk);
        mode_a = 1; start_a = 1; ready_a = 1;
        for (int i = 0; i < 512; i++) push(0, i);
        collect(0, 512, 1, 3, 10, 1, 5);
        check("scan2_final_addr", 32'(addr_a), 511);

        manual_read(1, 0, 0);
        manual_read(0, 1, 511);
        manual_read(1, 0, 0);
        manual_read(0, 0, 0);

        @(negedge clk);
        mode_a = 0; inc_a = 1; dec_a = 1;
        expect_ignored("ign_both_steps");
        @(negedge clk);
        mode_a = 1; inc_a = 1;
        expect_ignored("ign_step_auto");

        @(negedge clk);
        mode_b = 1; start_b = 1; ready_b = 1;
        for (int i = 0; i < 256; i++) push(1, i);
        collect(1, 256, 1, -1, 0, 0, 2);
        check("ip3601_final_addr", 32'(addr_b), 255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
